dm_responder: RTL
=================

Name: dm_responder

Overview:
Multi-cycle data-memory responder, the target end of the MEM-stage load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake.
- Applies a programmable access latency, then returns read data or a write acknowledgement over a second valid/ready handshake.
- Replaces the zero-latency data memory so the pipeline can be exercised against a stalling memory.

Parameters:
ADDR_W, 32, byte-address width of req_addr.
DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, minimum 4.
LATENCY, 2, cycles from request acceptance to rsp_valid rising; integer, minimum 1.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 = store, 0 = load.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data.
req_be  input  4  byte enables for a store; bit i enables byte i (bits [8i+7:8i]).
rsp_valid  output  1  response present.
rsp_ready  input  1  requester accepts the response.
rsp_rdata  output  32  load data; 0 for stores.
rsp_err  output  1  request rejected; tied to 0 unless DM_ALIGN_CHECK_EN is defined.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock, named clock. Reset is synchronous, active-high, and named reset.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, counter 0.
- Memory array contents are not reset.

FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Acceptance occurs when req_valid & req_ready on an edge.
  - On acceptance, latch write, word index, be and wdata. Word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo the memory size.
  - On acceptance, load counter = LATENCY-1 and go to WAIT.
  - Exception: if LATENCY == 1, perform the access on the acceptance edge and go directly to RESP.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each cycle.
  - On the edge where counter == 1, perform the access and go to RESP.
  - Result: rsp_valid is high exactly LATENCY cycles after the acceptance edge.
- Access:
  - Store: write only the enabled bytes; rsp_rdata = 0. A store with be == 0 leaves memory unchanged but still produces a response.
  - Load: rsp_rdata = full word; req_be is ignored.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake edge: rsp_valid = 0, rsp_rdata and rsp_err cleared, go to IDLE.
  - There is no same-cycle turnaround. req_ready rises the cycle after the response handshake, so the minimum period is LATENCY+1 cycles per transaction.
- Backpressure: rsp_ready low holds RESP indefinitely. req_valid seen in WAIT or RESP is not accepted.
- Reset mid-operation: returns to IDLE. A store accepted but not yet committed is discarded; a store already committed persists.
- Read-after-write: a load accepted after a store's response observes the stored data.
- Simultaneous reset and handshake: reset wins.

Optional Feature:
Macro: DM_ALIGN_CHECK_EN.
- Defined: a request is misaligned when req_be == 4'hF and req_addr[1:0] != 0, or req_be is 4'h3 or 4'hC and req_addr[0] != 0.
  - Misaligned requests follow the normal latency, but perform no memory write.
  - Their response carries rsp_err = 1 and rsp_rdata = 0.
- Undefined: rsp_err is constant 0, and req_addr[1:0] is ignored entirely.

Decomposition:
- Package dm_pkg:
  - dm_state_t enum {IDLE, WAIT, RESP}.
  - BE_WORD = 4'hF, BE_HALF_LO = 4'h3, BE_HALF_HI = 4'hC.
  - Helper function word_index(addr).
- Sub-module dm_bank: DEPTH_WORDS x 32 storage with byte-enabled synchronous write and synchronous read. It is instantiated once; the FSM, counter and handshake logic stay in dm_responder.

Test Plan:
1. LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, rsp_ready=1 -> rsp_valid 2 cycles after acceptance with rdata 0; a following load of 0x10 returns 0xDEADBEEF.
2. Byte enables: store 0x11223344 to 0x20 with be 4'hF, then store 0xAABBCCDD with be 4'b0101 -> load of 0x20 returns 0x11BB33DD.
3. Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable throughout, req_ready=0 and req_valid ignored; after rsp_ready=1, req_ready=1 on the next cycle.
4. Wrap and LATENCY=1: store 0x5A5A5A5A to DEPTH_WORDS*4 + 8 -> load of 0x8 returns 0x5A5A5A5A; response arrives 1 cycle after acceptance.
5. Reset mid-WAIT: LATENCY=4, reset asserted 2 cycles after a store to 0x30 is accepted -> outputs return to reset values; a later load of 0x30 returns the pre-store contents.
6. DM_ALIGN_CHECK_EN: store be 4'hF to 0x42 -> rsp_err=1, rdata=0, memory unchanged; store be 4'h3 to 0x42 -> rsp_err=0 and the write is performed.

Source files
------------

// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared types, constants and helpers for the data-memory responder.
//   dm_state_t     : responder FSM states (IDLE, WAIT, RESP)
//   BE_*           : byte-enable patterns for word and half-word accesses
//   word_index()   : byte address -> word index (masked to the memory size)
//   is_misaligned(): alignment rule used when DM_ALIGN_CHECK_EN is defined
// -----------------------------------------------------------------------------
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  localparam logic [3:0] BE_WORD    = 4'hF;
  localparam logic [3:0] BE_HALF_LO = 4'h3;
  localparam logic [3:0] BE_HALF_HI = 4'hC;

  // Drops the byte offset and keeps idx_w bits, so addresses wrap modulo
  // the memory size. Callers truncate the result to their index width.
  function automatic logic [31:0] word_index(input logic [63:0] addr,
                                             input int unsigned idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((addr >> 2) & mask);
  endfunction

  // Full words must be 4-byte aligned, half words 2-byte aligned.
  // Any other byte-enable pattern is never considered misaligned.
  function automatic logic is_misaligned(input logic [3:0] be,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (be == BE_WORD && addr_lo != 2'b00) begin
      mis = 1'b1;
    end
    if ((be == BE_HALF_LO || be == BE_HALF_HI) && addr_lo[0]) begin
      mis = 1'b1;
    end
    return mis;
  endfunction

endpackage

// File: rtl/dm_bank.sv
// -----------------------------------------------------------------------------
// dm_bank
// DEPTH_WORDS x 32-bit storage, built as four independent byte lanes so each
// lane maps onto its own block RAM with a plain write enable.
//   clock_i  : clock
//   we_i     : write strobe (combined with be_i per lane)
//   be_i     : byte enables, bit i selects bits [8i+7:8i]
//   re_i     : read strobe; rdata_o updates on the following edge only
//   addr_i   : word index
//   wdata_i  : write data
//   rdata_o  : registered read data, held until the next read strobe
// Contents are not reset.
// -----------------------------------------------------------------------------
module dm_bank import dm_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clock_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clock_i) begin
      if (we_i && be_i[gi]) begin
        mem_q[addr_i] <= wdata_i[8*gi +: 8];
      end
      if (re_i) begin
        rd_q <= mem_q[addr_i];
      end
    end

    assign rdata_o[8*gi +: 8] = rd_q;
  end

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// Multi-cycle data-memory target for the MEM-stage load/store interface.
// One request is accepted at a time; after LATENCY cycles the response is
// presented and held until the requester takes it.
//   clock, reset          : clock, synchronous active-high reset
//   req_valid / req_ready : request handshake
//   req_write, req_addr,
//   req_wdata, req_be     : request payload (byte address, byte enables)
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata             : load data (0 for stores and rejected requests)
//   rsp_err               : misaligned request (only with DM_ALIGN_CHECK_EN)
//   busy                  : high whenever the FSM is not in IDLE
// Optional build macro: DM_ALIGN_CHECK_EN enables the alignment check; when
// it is undefined rsp_err stays 0 and req_addr[1:0] is ignored.
// -----------------------------------------------------------------------------
module dm_responder import dm_pkg::*; #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int   IDX_W = $clog2(DEPTH_WORDS);
  localparam int   CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic LAT1  = (LATENCY == 1);

  dm_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             write_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic             mis_q;
  logic             rd_sel_q;    // response carries bank read data
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             busy_q;

  logic [IDX_W-1:0] req_idx_d;
  logic             req_mis_d;
  logic             acc_fire_d;
  logic             acc_write_d;
  logic [IDX_W-1:0] acc_idx_d;
  logic [3:0]       acc_be_d;
  logic [31:0]      acc_wdata_d;
  logic             acc_mis_d;
  logic [31:0]      bank_rdata;
  logic             unused_addr;

  assign req_idx_d = IDX_W'(word_index(64'(req_addr), IDX_W));

`ifdef DM_ALIGN_CHECK_EN
  assign req_mis_d = is_misaligned(req_be, req_addr[1:0]);
`else
  assign req_mis_d = 1'b0;
`endif

  // Upper address bits wrap away by design.
  assign unused_addr = ^req_addr;

  // The access happens on the acceptance edge when LATENCY is 1 (payload
  // comes straight from the request port), otherwise on the last WAIT edge
  // from the latched payload. Reset on that edge cancels the access.
  always_comb begin
    acc_fire_d  = 1'b0;
    acc_write_d = write_q;
    acc_idx_d   = idx_q;
    acc_be_d    = be_q;
    acc_wdata_d = wdata_q;
    acc_mis_d   = mis_q;
    if (state_q == IDLE) begin
      acc_fire_d  = LAT1 && req_valid && !reset;
      acc_write_d = req_write;
      acc_idx_d   = req_idx_d;
      acc_be_d    = req_be;
      acc_wdata_d = req_wdata;
      acc_mis_d   = req_mis_d;
    end else if (state_q == WAIT) begin
      acc_fire_d = (cnt_q == CNT_W'(1)) && !reset;
    end
  end

  dm_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clock_i (clock),
    .we_i    (acc_fire_d && acc_write_d && !acc_mis_d),
    .be_i    (acc_be_d),
    .re_i    (acc_fire_d && !acc_write_d && !acc_mis_d),
    .addr_i  (acc_idx_d),
    .wdata_i (acc_wdata_d),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            idx_q       <= req_idx_d;
            be_q        <= req_be;
            wdata_q     <= req_wdata;
            mis_q       <= req_mis_d;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (LAT1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= req_mis_d;
              rd_sel_q    <= !req_write && !req_mis_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= mis_q;
            rd_sel_q    <= !write_q && !mis_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rd_sel_q    <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  // Bank read register only moves on a load access, so this stays stable
  // for the whole response and drops to 0 after the handshake.
  assign rsp_rdata = rd_sel_q ? bank_rdata : 32'd0;

endmodule
